// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory address/data, hazard-unit controls,
// redirect inputs from ID/EX, and the IF/ID register outputs to the decoder.
interface fetch_if;
  logic [31:0] pc_address;
  logic [31:0] ir;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] if_id_ir;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        halted;
  logic        fault;

  // Fetch unit side
  modport master (
    output pc_address, if_id_ir, if_id_pc_plus4, if_id_valid, halted, fault,
    input  ir, stall, flush, branch_taken, branch_target, jump, jump_index
  );

  // Environment side (memory, hazard unit, later pipeline stages)
  modport slave (
    input  pc_address, if_id_ir, if_id_pc_plus4, if_id_valid, halted, fault,
    output ir, stall, flush, branch_taken, branch_target, jump, jump_index
  );
endinterface

// File: rtl/fetch_unit.sv
// PC register and IF stage: drives instruction-memory address, captures the
// returned word into IF/ID, resolves next-PC (jump > branch > stall > +4),
// and stops on the end-of-program sentinel or on an address fault.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF,
  parameter int unsigned IMEM_WORDS = 8192
) (
  input logic     clk,
  input logic     rst_n,
  fetch_if.master bus
);

  // 33 bits so a full 4 GiB memory size cannot overflow the limit.
  localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) * 33'd4;

  typedef enum logic [1:0] {StRun, StHalt, StFault} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] if_id_ir_q;
  logic [31:0] if_id_pc_plus4_q;
  logic        if_id_valid_q;
  logic        halted_q;
  logic        fault_q;

  logic [31:0] pc_plus4;
  logic [31:0] jump_pc;
  logic [31:0] branch_pc;
  logic        branch_misaligned;
  logic        out_of_range;

  // Redirect targets and fetch-address checks
  always_comb begin
    pc_plus4          = pc_q + 32'd4;
    // Jump is resolved in ID, so the region bits come from the instruction in IF/ID.
    jump_pc           = {bus.if_id_pc_plus4[31:28], bus.jump_index, 2'b00};
    branch_pc         = {bus.branch_target[31:2], 2'b00};
    branch_misaligned = (bus.branch_target[1:0] != 2'b00);
    out_of_range      = ({1'b0, pc_q} >= IMEM_BYTES);
  end

  // FSM, PC and IF/ID register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= StRun;
      pc_q             <= RESET_PC;
      if_id_ir_q       <= 32'd0;
      if_id_pc_plus4_q <= 32'd0;
      if_id_valid_q    <= 1'b0;
      halted_q         <= 1'b0;
      fault_q          <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (out_of_range) begin
            state_q          <= StFault;
            fault_q          <= 1'b1;
            if_id_ir_q       <= 32'd0;
            if_id_pc_plus4_q <= 32'd0;
            if_id_valid_q    <= 1'b0;
          end else if (bus.jump) begin
            pc_q             <= jump_pc;
            if_id_ir_q       <= 32'd0;
            if_id_pc_plus4_q <= 32'd0;
            if_id_valid_q    <= 1'b0;
          end else if (bus.branch_taken) begin
            if (branch_misaligned) begin
              state_q <= StFault;
              fault_q <= 1'b1;
            end else begin
              pc_q <= branch_pc;
            end
            if_id_ir_q       <= 32'd0;
            if_id_pc_plus4_q <= 32'd0;
            if_id_valid_q    <= 1'b0;
          end else if (bus.stall) begin
            // PC holds; IF/ID holds unless the hazard unit also flushes.
            if (bus.flush) begin
              if_id_ir_q       <= 32'd0;
              if_id_pc_plus4_q <= 32'd0;
              if_id_valid_q    <= 1'b0;
            end
          end else if (bus.flush) begin
            pc_q             <= pc_plus4;
            if_id_ir_q       <= 32'd0;
            if_id_pc_plus4_q <= 32'd0;
            if_id_valid_q    <= 1'b0;
          end else if (bus.ir == HALT_WORD) begin
            // Sentinel is never passed to decode; PC stays on it.
            state_q          <= StHalt;
            halted_q         <= 1'b1;
            if_id_ir_q       <= 32'd0;
            if_id_pc_plus4_q <= 32'd0;
            if_id_valid_q    <= 1'b0;
          end else begin
            pc_q             <= pc_plus4;
            if_id_ir_q       <= bus.ir;
            if_id_pc_plus4_q <= pc_plus4;
            if_id_valid_q    <= 1'b1;
          end
        end

        StHalt: begin
          // An older in-flight redirect means the sentinel was a wrong-path fetch.
          if (bus.jump) begin
            state_q  <= StRun;
            halted_q <= 1'b0;
            pc_q     <= jump_pc;
          end else if (bus.branch_taken) begin
            halted_q <= 1'b0;
            if (branch_misaligned) begin
              state_q <= StFault;
              fault_q <= 1'b1;
            end else begin
              state_q <= StRun;
              pc_q    <= branch_pc;
            end
          end
          if_id_ir_q       <= 32'd0;
          if_id_pc_plus4_q <= 32'd0;
          if_id_valid_q    <= 1'b0;
        end

        StFault: begin
          if_id_ir_q       <= 32'd0;
          if_id_pc_plus4_q <= 32'd0;
          if_id_valid_q    <= 1'b0;
        end

        default: begin
          state_q <= StFault;
          fault_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.pc_address     = pc_q;
  assign bus.if_id_ir       = if_id_ir_q;
  assign bus.if_id_pc_plus4 = if_id_pc_plus4_q;
  assign bus.if_id_valid    = if_id_valid_q;
  assign bus.halted         = halted_q;
  assign bus.fault          = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Instruction memory returns 0x1000_0000|addr
// for every address except halt_addr, which returns the sentinel word.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] halt_addr = 32'hFFFF_FFF0;
  int          n_cmp = 0;
  int          n_bad = 0;

  fetch_if bus ();

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .HALT_WORD (32'hFFFF_FFFF),
    .IMEM_WORDS(8192)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign bus.ir = (bus.pc_address == halt_addr) ? 32'hFFFF_FFFF
                                                : (32'h1000_0000 | bus.pc_address);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall         = 1'b0;
    bus.flush         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'd0;
    bus.jump          = 1'b0;
    bus.jump_index    = 26'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    step();
    n_cmp++; if (bus.pc_address !== 32'h0) begin n_bad++;
      $display("FAIL reset_pc: got %h want %h", bus.pc_address, 32'h0); end
    n_cmp++; if (bus.if_id_ir !== 32'h0) begin n_bad++;
      $display("FAIL reset_ir: got %h want %h", bus.if_id_ir, 32'h0); end
    n_cmp++; if (bus.if_id_pc_plus4 !== 32'h0) begin n_bad++;
      $display("FAIL reset_pc4: got %h want %h", bus.if_id_pc_plus4, 32'h0); end
    n_cmp++; if ({bus.if_id_valid, bus.halted, bus.fault} !== 3'b000) begin n_bad++;
      $display("FAIL reset_flags: got %b want 000",
               {bus.if_id_valid, bus.halted, bus.fault}); end
  endtask

  task automatic test_sequential();
    halt_addr = 32'd12;
    rst_n     = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      n_cmp++; if (bus.pc_address !== 32'(4 * i)) begin n_bad++;
        $display("FAIL seq_pc[%0d]: got %h want %h", i, bus.pc_address, 32'(4 * i)); end
      n_cmp++; if (bus.if_id_pc_plus4 !== 32'(4 * i)) begin n_bad++;
        $display("FAIL seq_pc4[%0d]: got %h want %h", i, bus.if_id_pc_plus4, 32'(4 * i)); end
      n_cmp++; if (bus.if_id_ir !== (32'h1000_0000 | 32'(4 * i - 4))) begin n_bad++;
        $display("FAIL seq_ir[%0d]: got %h want %h", i, bus.if_id_ir,
                 32'h1000_0000 | 32'(4 * i - 4)); end
      n_cmp++; if (bus.if_id_valid !== 1'b1) begin n_bad++;
        $display("FAIL seq_valid[%0d]: got %b want 1", i, bus.if_id_valid); end
    end
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if ({bus.halted, bus.if_id_valid} !== 2'b10) begin n_bad++;
        $display("FAIL seq_halt[%0d]: got halted,valid=%b want 10", i,
                 {bus.halted, bus.if_id_valid}); end
      n_cmp++; if (bus.pc_address !== 32'd12) begin n_bad++;
        $display("FAIL seq_halt_pc[%0d]: got %h want %h", i, bus.pc_address, 32'd12); end
    end
  endtask

  task automatic test_reset_mid_halt();
    // Reset must win over stall and a pending branch.
    rst_n             = 1'b0;
    bus.stall         = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h40;
    step();
    n_cmp++; if (bus.pc_address !== 32'h0) begin n_bad++;
      $display("FAIL rsthalt_pc: got %h want %h", bus.pc_address, 32'h0); end
    n_cmp++; if ({bus.if_id_ir, bus.if_id_pc_plus4} !== 64'h0) begin n_bad++;
      $display("FAIL rsthalt_ifid: got %h want 0", {bus.if_id_ir, bus.if_id_pc_plus4}); end
    n_cmp++; if ({bus.if_id_valid, bus.halted, bus.fault} !== 3'b000) begin n_bad++;
      $display("FAIL rsthalt_flags: got %b want 000",
               {bus.if_id_valid, bus.halted, bus.fault}); end
    clear_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_halt_recovery();
    halt_addr = 32'd4;
    step();
    step();
    n_cmp++; if ({bus.halted, bus.pc_address} !== {1'b1, 32'd4}) begin n_bad++;
      $display("FAIL hrec_halted: got halted=%b pc=%h want 1 %h",
               bus.halted, bus.pc_address, 32'd4); end
    halt_addr         = 32'hFFFF_FFF0;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h20;
    step();
    clear_inputs();
    n_cmp++; if ({bus.halted, bus.if_id_valid} !== 2'b00) begin n_bad++;
      $display("FAIL hrec_flags: got halted,valid=%b want 00",
               {bus.halted, bus.if_id_valid}); end
    n_cmp++; if (bus.pc_address !== 32'h20) begin n_bad++;
      $display("FAIL hrec_pc: got %h want %h", bus.pc_address, 32'h20); end
    step();
    n_cmp++; if ({bus.pc_address, bus.if_id_ir, bus.if_id_pc_plus4, bus.if_id_valid} !==
                 {32'h24, 32'h1000_0020, 32'h24, 1'b1}) begin n_bad++;
      $display("FAIL hrec_resume: got pc=%h ir=%h pc4=%h v=%b want 24 10000020 24 1",
               bus.pc_address, bus.if_id_ir, bus.if_id_pc_plus4, bus.if_id_valid); end
  endtask

  task automatic test_stall();
    do_reset();
    step();
    step();
    bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (bus.pc_address !== 32'd8) begin n_bad++;
        $display("FAIL stall_pc[%0d]: got %h want %h", i, bus.pc_address, 32'd8); end
      n_cmp++; if ({bus.if_id_ir, bus.if_id_pc_plus4, bus.if_id_valid} !==
                   {32'h1000_0004, 32'd8, 1'b1}) begin n_bad++;
        $display("FAIL stall_ifid[%0d]: got ir=%h pc4=%h v=%b want 10000004 8 1", i,
                 bus.if_id_ir, bus.if_id_pc_plus4, bus.if_id_valid); end
    end
    bus.stall = 1'b0;
    step();
    n_cmp++; if ({bus.pc_address, bus.if_id_ir} !== {32'd12, 32'h1000_0008}) begin n_bad++;
      $display("FAIL stall_release: got pc=%h ir=%h want c 10000008",
               bus.pc_address, bus.if_id_ir); end
  endtask

  task automatic test_branch_stall();
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h40;
    bus.stall         = 1'b1;
    step();
    clear_inputs();
    n_cmp++; if ({bus.pc_address, bus.if_id_valid} !== {32'h40, 1'b0}) begin n_bad++;
      $display("FAIL br_stall: got pc=%h v=%b want 40 0", bus.pc_address, bus.if_id_valid); end
    step();
    n_cmp++; if ({bus.pc_address, bus.if_id_ir} !== {32'h44, 32'h1000_0040}) begin n_bad++;
      $display("FAIL br_next: got pc=%h ir=%h want 44 10000040",
               bus.pc_address, bus.if_id_ir); end
  endtask

  task automatic test_flush();
    do_reset();
    step();
    bus.flush = 1'b1;
    step();
    n_cmp++; if ({bus.pc_address, bus.if_id_valid} !== {32'd8, 1'b0}) begin n_bad++;
      $display("FAIL flush: got pc=%h v=%b want 8 0", bus.pc_address, bus.if_id_valid); end
    // Sentinel under flush must not halt.
    halt_addr = 32'd8;
    step();
    n_cmp++; if ({bus.pc_address, bus.halted} !== {32'd12, 1'b0}) begin n_bad++;
      $display("FAIL flush_sentinel: got pc=%h halted=%b want c 0",
               bus.pc_address, bus.halted); end
    clear_inputs();
    halt_addr = 32'hFFFF_FFF0;
  endtask

  task automatic test_jump();
    do_reset();
    step();
    step();
    bus.jump       = 1'b1;
    bus.jump_index = 26'h000_0010;
    step();
    clear_inputs();
    n_cmp++; if ({bus.pc_address, bus.if_id_valid} !== {32'h40, 1'b0}) begin n_bad++;
      $display("FAIL jump: got pc=%h v=%b want 40 0", bus.pc_address, bus.if_id_valid); end
    step();
    bus.jump          = 1'b1;
    bus.jump_index    = 26'h000_0010;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h80;
    step();
    clear_inputs();
    n_cmp++; if (bus.pc_address !== 32'h40) begin n_bad++;
      $display("FAIL jump_over_branch: got %h want %h", bus.pc_address, 32'h40); end
  endtask

  task automatic test_misaligned();
    do_reset();
    step();
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h42;
    step();
    n_cmp++; if ({bus.fault, bus.halted, bus.if_id_valid, bus.pc_address} !==
                 {3'b100, 32'd4}) begin n_bad++;
      $display("FAIL misalign: got f,h,v=%b pc=%h want 100 4",
               {bus.fault, bus.halted, bus.if_id_valid}, bus.pc_address); end
    bus.branch_target = 32'h40;
    step();
    clear_inputs();
    step();
    n_cmp++; if ({bus.fault, bus.pc_address} !== {1'b1, 32'd4}) begin n_bad++;
      $display("FAIL misalign_frozen: got f=%b pc=%h want 1 4", bus.fault, bus.pc_address); end
  endtask

  task automatic test_out_of_range();
    do_reset();
    n_cmp++; if (bus.fault !== 1'b0) begin n_bad++;
      $display("FAIL oor_reset_fault: got %b want 0", bus.fault); end
    step();
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h7FFC;
    step();
    clear_inputs();
    step();
    n_cmp++; if ({bus.pc_address, bus.fault, bus.if_id_valid, bus.if_id_ir} !==
                 {32'h8000, 2'b01, 32'h1000_7FFC}) begin n_bad++;
      $display("FAIL oor_last_word: got pc=%h f=%b v=%b ir=%h want 8000 0 1 10007ffc",
               bus.pc_address, bus.fault, bus.if_id_valid, bus.if_id_ir); end
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if ({bus.pc_address, bus.fault, bus.if_id_valid} !==
                   {32'h8000, 2'b10}) begin n_bad++;
        $display("FAIL oor_fault[%0d]: got pc=%h f=%b v=%b want 8000 1 0", i,
                 bus.pc_address, bus.fault, bus.if_id_valid); end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_sequential();
    test_reset_mid_halt();
    test_halt_recovery();
    test_stall();
    test_branch_stall();
    test_flush();
    test_jump();
    test_misaligned();
    test_out_of_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
PC and fetch stage that sits directly upstream of instruction memory. It holds the program counter and drives pc_address to the instruction memory. It captures the returned ir into the IF/ID pipeline register for the decoder. It handles sequential, branch and jump next-PC selection, stall and flush from the hazard unit, and halting on the end-of-program sentinel word.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
HALT_WORD, 32'hFFFFFFFF, instruction word that marks end of program
IMEM_WORDS, 8192, instruction memory depth in words; fetch address at or above IMEM_WORDS*4 is a fault

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
pc_address  output  32  byte address to instruction memory, driven directly from the PC register
ir  input  32  instruction word returned combinationally by instruction memory for pc_address
stall  input  1  hazard unit: hold PC and IF/ID contents
flush  input  1  hazard unit: load bubble into IF/ID
branch_taken  input  1  branch resolved taken this cycle
branch_target  input  32  branch destination byte address
jump  input  1  J-type jump this cycle
jump_index  input  26  instr_index field of the jump
if_id_ir  output  32  registered instruction to decode
if_id_pc_plus4  output  32  registered PC+4 of that instruction
if_id_valid  output  1  if_id_ir holds a real instruction
halted  output  1  fetch stopped on HALT_WORD
fault  output  1  fetch address out of range or misaligned redirect, sticky until reset

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset, when rst_n=0 at a clock edge:
  - PC=RESET_PC.
  - if_id_ir=0, if_id_pc_plus4=0, if_id_valid=0.
  - halted=0, fault=0, state=RUN.
  - Reset overrides every other input, including mid-halt and mid-stall.
- pc_address=PC, no added latency. ir is valid in the same cycle. IF/ID captures at the next edge, giving 1-cycle fetch latency.
- State machine:
  - States: RUN, HALT, FAULT.
  - RUN -> HALT when ir==HALT_WORD and no redirect, stall or flush that cycle.
  - RUN -> FAULT when pc_address >= IMEM_WORDS*4.
  - HALT -> RUN on a redirect.
  - FAULT exits only through reset.
- Next-PC priority in RUN, highest first:
  1. jump: PC={PC_plus4_of_if_id[31:28], jump_index, 2'b00}. The jump is resolved in ID, so the upper bits come from if_id_pc_plus4.
  2. branch_taken: PC={branch_target[31:2],2'b00}. If branch_target[1:0]!=0, set fault and go to FAULT.
  3. stall: PC holds.
  4. Otherwise PC=PC+4, with 32-bit wrap-around modulo 2^32 (the range check then faults).
- jump and branch_taken both high: jump wins.
- IF/ID update:
  - Redirect or flush: IF/ID <= bubble (ir=0, valid=0). The instruction fetched on the wrong path is discarded. Redirect overrides stall.
  - stall with no redirect or flush: IF/ID holds.
  - Otherwise: if_id_ir=ir, if_id_pc_plus4=PC+4, if_id_valid=1.
  - The HALT_WORD is never loaded into IF/ID; a bubble is loaded instead.
- HALT state:
  - halted=1, PC frozen at the sentinel address, IF/ID loads bubbles.
  - A redirect from an older in-flight instruction returns to RUN at the target and clears halted. The sentinel was a wrong-path fetch.
- FAULT state: PC frozen, IF/ID bubbles, fault=1, halted=0.
- The sentinel check uses the ir value only when state=RUN and stall=0.

Test Plan:
- Sequential fetch: reset with RESET_PC=0, memory holds 3 instructions then 32'hFFFFFFFF.
  - pc_address steps 0,4,8,12.
  - if_id_pc_plus4 steps 4,8,12.
  - if_id_valid=1 for 3 cycles, then halted=1 with PC=12 held and if_id_valid=0.
- Stall: stall=1 for 2 cycles at PC=8.
  - pc_address stays 8 and IF/ID holds the word from PC=4.
  - After release, PC goes to 12.
- Branch with simultaneous stall: branch_taken=1, branch_target=0x40, stall=1.
  - Next pc_address=0x40 and if_id_valid=0.
  - Misaligned target 0x42 instead: fault=1 and PC frozen.
- Jump: jump=1, jump_index=26'h0000010, if_id_pc_plus4=0x00000008.
  - PC=0x00000040.
  - jump and branch_taken (target 0x80) together: PC=0x40.
- Halt recovery: halted=1, then branch_taken=1 with target 0x20.
  - halted=0, pc_address=0x20, fetch resumes.
- Reset mid-halt and out of range:
  - rst_n=0 while halted: PC=RESET_PC, all outputs 0.
  - Separately, fetch reaching 0x8000 (IMEM_WORDS*4): fault=1.
